// File: rtl/cell_sort_pkg.sv
// Shared types and helpers for the systolic cell sorter and its readout.
// Empty-entry detection lives here so the sorter reset value and the drain agree.
package cell_sort_pkg;

  localparam int MAX_SORTB = 64;
  localparam int MAX_METAB = 256;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_QUIET,
    STREAM
  } readout_state_t;

  // Low sortb bits hold the empty key; ascending sorters park empties at all ones.
  function automatic logic [MAX_SORTB-1:0] empty_key(input bit rev, input int sortb);
    logic [MAX_SORTB-1:0] key;
    key = '0;
    if (rev) key = (MAX_SORTB'(1) << sortb) - MAX_SORTB'(1);
    return key;
  endfunction

  function automatic logic is_empty(input logic [MAX_SORTB-1:0] key,
                                    input logic [MAX_METAB-1:0] meta,
                                    input bit rev, input int sortb);
    return (key == empty_key(rev, sortb)) && (meta == '0);
  endfunction

endpackage

// File: rtl/readout_mux.sv
// Registered selection of one snapshot entry plus the emptiness of the entry after it.
// On the capture edge the first entry comes straight from the live cells.
module readout_mux
  import cell_sort_pkg::*;
#(
  parameter int NCELLS = 16,
  parameter int SORTB  = 8,
  parameter int METAB  = 32,
  parameter int REV    = 0,
  parameter int IW     = $clog2(NCELLS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_first,
  input  logic                    load,
  input  logic [IW-1:0]           sel,
  input  logic [SORTB-1:0]        first_key,
  input  logic [METAB-1:0]        first_meta,
  input  logic [SORTB-1:0]        second_key,
  input  logic [METAB-1:0]        second_meta,
  input  logic [NCELLS*SORTB-1:0] snap_data,
  input  logic [NCELLS*METAB-1:0] snap_meta,
  output logic [SORTB-1:0]        cur_key,
  output logic [METAB-1:0]        cur_meta,
  output logic                    next_empty
);

  logic [SORTB-1:0] key_arr  [NCELLS];
  logic [METAB-1:0] meta_arr [NCELLS];
  logic [NCELLS:1]  later_empty;
  logic [IW:0]      sel_plus;
  logic             second_empty;

  genvar gi;
  for (gi = 0; gi < NCELLS; gi++) begin : g_unpack
    assign key_arr[gi]  = snap_data[gi*SORTB +: SORTB];
    assign meta_arr[gi] = snap_meta[gi*METAB +: METAB];
  end

  for (gi = 1; gi < NCELLS; gi++) begin : g_empty
    assign later_empty[gi] = is_empty(MAX_SORTB'(key_arr[gi]), MAX_METAB'(meta_arr[gi]),
                                      REV != 0, SORTB);
  end
  // Running off the end of the sorter looks like an empty successor.
  assign later_empty[NCELLS] = 1'b1;

  assign second_empty = is_empty(MAX_SORTB'(second_key), MAX_METAB'(second_meta), REV != 0, SORTB);
  assign sel_plus     = {1'b0, sel} + (IW+1)'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_key    <= '0;
      cur_meta   <= '0;
      next_empty <= 1'b0;
    end else if (load_first) begin
      cur_key    <= first_key;
      cur_meta   <= first_meta;
      next_empty <= second_empty;
    end else if (load) begin
      cur_key    <= key_arr[sel];
      cur_meta   <= meta_arr[sel];
      next_empty <= later_empty[sel_plus];
    end
  end

endmodule

// File: rtl/cell_sort_readout.sv
// Drain side of the systolic cell sorter: snapshot, clear the sorter, then stream
// the sorted entries best-first on a valid/ready port with index/last/count sideband.
module cell_sort_readout
  import cell_sort_pkg::*;
#(
  parameter int NCELLS     = 16,
  parameter int SORTB      = 8,
  parameter int METAB      = 32,
  parameter int REV        = 0,
  parameter int NOUT       = 16,
  parameter int SKIP_EMPTY = 1,
  localparam int IW        = $clog2(NCELLS),
  localparam int CW        = $clog2(NCELLS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCELLS*SORTB-1:0] cells_data_i,
  input  logic [NCELLS*METAB-1:0] cells_metadata_i,
  input  logic                    sorter_dav_i,
  input  logic                    start_i,
  output logic                    sorter_clear_o,
  output logic                    busy_o,
  output logic [SORTB-1:0]        m_data_o,
  output logic [METAB-1:0]        m_metadata_o,
  output logic [IW-1:0]           m_index_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic                    done_o,
  output logic [CW-1:0]           count_o
);

  if (NOUT < 1 || NOUT > NCELLS || NCELLS < 2 || SORTB > MAX_SORTB || METAB > MAX_METAB)
  begin : g_param_check
    $error("cell_sort_readout: need 1 <= NOUT <= NCELLS, NCELLS >= 2, widths within package limits");
  end

  readout_state_t          state_reg, state_next;
  logic [NCELLS*SORTB-1:0] snap_data_reg;
  logic [NCELLS*METAB-1:0] snap_meta_reg;
  logic [IW-1:0]           index_reg;
  logic [CW-1:0]           count_reg;
  logic                    valid_reg, clear_reg, done_reg;
  logic                    capture, advance, finish;
  logic                    first_empty, skip_first, next_empty, xfer, is_last;

  assign first_empty = is_empty(MAX_SORTB'(cells_data_i[SORTB-1:0]),
                                MAX_METAB'(cells_metadata_i[METAB-1:0]), REV != 0, SORTB);
  assign skip_first  = (SKIP_EMPTY != 0) && first_empty;
  assign xfer        = valid_reg && m_ready_i;
  assign is_last     = (index_reg == IW'(NOUT - 1)) || ((SKIP_EMPTY != 0) && next_empty);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // A start arriving while done_o pulses belongs to the finished readout and is dropped.
  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_i && !done_reg) state_next = WAIT_QUIET;
      end
      WAIT_QUIET: begin
        if (!sorter_dav_i) begin
          capture    = 1'b1;
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (done_reg) begin
          state_next = IDLE;
        end else if (xfer) begin
          if (is_last) begin
            finish     = 1'b1;
            state_next = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      snap_data_reg <= cells_data_i;
      snap_meta_reg <= cells_metadata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      index_reg <= '0;
      count_reg <= '0;
      valid_reg <= 1'b0;
      clear_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      clear_reg <= capture;
      done_reg  <= finish || (capture && skip_first);
      if (capture) begin
        index_reg <= '0;
        valid_reg <= !skip_first;
        if (skip_first) count_reg <= '0;
      end
      if (advance) index_reg <= index_reg + IW'(1);
      if (finish) begin
        valid_reg <= 1'b0;
        count_reg <= CW'(index_reg) + CW'(1);
      end
    end
  end

  readout_mux #(
    .NCELLS(NCELLS),
    .SORTB (SORTB),
    .METAB (METAB),
    .REV   (REV),
    .IW    (IW)
  ) u_mux (
    .clk        (clk),
    .rst        (rst),
    .load_first (capture),
    .load       (advance),
    .sel        (index_reg + IW'(1)),
    .first_key  (cells_data_i[SORTB-1:0]),
    .first_meta (cells_metadata_i[METAB-1:0]),
    .second_key (cells_data_i[SORTB +: SORTB]),
    .second_meta(cells_metadata_i[METAB +: METAB]),
    .snap_data  (snap_data_reg),
    .snap_meta  (snap_meta_reg),
    .cur_key    (m_data_o),
    .cur_meta   (m_metadata_o),
    .next_empty (next_empty)
  );

  assign sorter_clear_o = clear_reg;
  assign busy_o         = (state_reg != IDLE);
  assign m_valid_o      = valid_reg;
  assign m_last_o       = valid_reg && is_last;
  assign m_index_o      = index_reg;
  assign done_o         = done_reg;
  assign count_o        = count_reg;

endmodule

// File: tb/tb_cell_sort_readout.sv
// Directed bench for cell_sort_readout: one REV=0 instance for most scenarios and
// one REV=1 instance for the ascending-order empty-key case.
module tb_cell_sort_readout;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  cells_data = '0;
  logic [127:0] cells_meta = '0;
  logic         dav = 1'b0;
  logic         start0 = 1'b0;
  logic         start1 = 1'b0;
  logic         m_ready = 1'b0;

  logic        clear0, busy0, last0, valid0, done0;
  logic [7:0]  data0;
  logic [31:0] meta0;
  logic [1:0]  idx0;
  logic [2:0]  count0;
  logic        clear1, busy1, last1, valid1, done1;
  logic [7:0]  data1;
  logic [31:0] meta1;
  logic [1:0]  idx1;
  logic [2:0]  count1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cell_sort_readout #(
    .NCELLS(4), .SORTB(8), .METAB(32), .REV(0), .NOUT(4), .SKIP_EMPTY(1)
  ) dut0 (
    .clk(clk), .rst(rst), .cells_data_i(cells_data), .cells_metadata_i(cells_meta),
    .sorter_dav_i(dav), .start_i(start0), .sorter_clear_o(clear0), .busy_o(busy0),
    .m_data_o(data0), .m_metadata_o(meta0), .m_index_o(idx0), .m_last_o(last0),
    .m_valid_o(valid0), .m_ready_i(m_ready), .done_o(done0), .count_o(count0)
  );

  cell_sort_readout #(
    .NCELLS(4), .SORTB(8), .METAB(32), .REV(1), .NOUT(4), .SKIP_EMPTY(1)
  ) dut1 (
    .clk(clk), .rst(rst), .cells_data_i(cells_data), .cells_metadata_i(cells_meta),
    .sorter_dav_i(dav), .start_i(start1), .sorter_clear_o(clear1), .busy_o(busy1),
    .m_data_o(data1), .m_metadata_o(meta1), .m_index_o(idx1), .m_last_o(last1),
    .m_valid_o(valid1), .m_ready_i(m_ready), .done_o(done1), .count_o(count1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({clear0, busy0, valid0, last0, done0} !== 5'b0 || data0 !== 8'h0 || meta0 !== 32'h0 ||
        idx0 !== 2'd0 || count0 !== 3'd0) begin
      failures++;
      $display("FAIL reset_dut0 ctl=%b data=%h meta=%h idx=%0d count=%0d required all zero",
               {clear0, busy0, valid0, last0, done0}, data0, meta0, idx0, count0);
    end
    checks++;
    if ({clear1, busy1, valid1, last1, done1} !== 5'b0 || data1 !== 8'h0 || meta1 !== 32'h0 ||
        idx1 !== 2'd0 || count1 !== 3'd0) begin
      failures++;
      $display("FAIL reset_dut1 ctl=%b data=%h meta=%h idx=%0d count=%0d required all zero",
               {clear1, busy1, valid1, last1, done1}, data1, meta1, idx1, count1);
    end
    rst = 1'b0;
    tick();
  endtask

  // Ends in the done_o cycle so test_back_to_back can probe the start-during-done case.
  task automatic test_full_readout;
    logic [7:0] ed [4] = '{8'h90, 8'h70, 8'h40, 8'h10};
    cells_data = 32'h1040_7090;
    cells_meta = {32'd4, 32'd3, 32'd2, 32'd1};
    m_ready = 1'b1;
    dav = 1'b0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    checks++;
    if (busy0 !== 1'b1 || clear0 !== 1'b0 || valid0 !== 1'b0) begin
      failures++;
      $display("FAIL full_wait busy=%b clear=%b valid=%b required busy=1 clear=0 valid=0",
               busy0, clear0, valid0);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (valid0 !== 1'b1 || clear0 !== (i == 0) || data0 !== ed[i] || meta0 !== 32'(i + 1) ||
          idx0 !== 2'(i) || last0 !== (i == 3) || done0 !== 1'b0) begin
        failures++;
        $display("FAIL full_beat%0d valid=%b clear=%b data=%h meta=%0d idx=%0d last=%b required data=%h meta=%0d idx=%0d",
                 i, valid0, clear0, data0, meta0, idx0, last0, ed[i], i + 1, i);
      end
      tick();
    end
    checks++;
    if (done0 !== 1'b1 || count0 !== 3'd4 || valid0 !== 1'b0 || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL full_done done=%b count=%0d valid=%b busy=%b required done=1 count=4 valid=0 busy=0",
               done0, count0, valid0, busy0);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] ed [4] = '{8'h90, 8'h70, 8'h40, 8'h10};
    start0 = 1'b1;
    tick();
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_start_in_done busy=%b done=%b required busy=0 done=0", busy0, done0);
    end
    tick();
    start0 = 1'b0;
    checks++;
    if (busy0 !== 1'b1) begin
      failures++;
      $display("FAIL b2b_start_accept busy=%b required 1", busy0);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (valid0 !== 1'b1 || data0 !== ed[i] || idx0 !== 2'(i) || last0 !== (i == 3)) begin
        failures++;
        $display("FAIL b2b_beat%0d valid=%b data=%h idx=%0d last=%b required data=%h idx=%0d",
                 i, valid0, data0, idx0, last0, ed[i], i);
      end
      tick();
    end
    checks++;
    if (done0 !== 1'b1 || count0 !== 3'd4) begin
      failures++;
      $display("FAIL b2b_done done=%b count=%0d required done=1 count=4", done0, count0);
    end
    tick();
  endtask

  task automatic test_early_stop;
    cells_data = 32'h0000_2255;
    cells_meta = {32'd0, 32'd0, 32'd8, 32'd7};
    m_ready = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    checks++;
    if (valid0 !== 1'b1 || data0 !== 8'h55 || meta0 !== 32'd7 || idx0 !== 2'd0 || last0 !== 1'b0) begin
      failures++;
      $display("FAIL early_beat0 valid=%b data=%h meta=%0d idx=%0d last=%b required 1 55 7 0 0",
               valid0, data0, meta0, idx0, last0);
    end
    tick();
    checks++;
    if (valid0 !== 1'b1 || data0 !== 8'h22 || meta0 !== 32'd8 || idx0 !== 2'd1 || last0 !== 1'b1) begin
      failures++;
      $display("FAIL early_beat1 valid=%b data=%h meta=%0d idx=%0d last=%b required 1 22 8 1 1",
               valid0, data0, meta0, idx0, last0);
    end
    tick();
    checks++;
    if (done0 !== 1'b1 || count0 !== 3'd2 || valid0 !== 1'b0) begin
      failures++;
      $display("FAIL early_done done=%b count=%0d valid=%b required done=1 count=2 valid=0",
               done0, count0, valid0);
    end
    tick();
  endtask

  task automatic test_empty_sorter;
    cells_data = '0;
    cells_meta = '0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    checks++;
    if (clear0 !== 1'b1 || done0 !== 1'b1 || count0 !== 3'd0 || valid0 !== 1'b0 || busy0 !== 1'b1) begin
      failures++;
      $display("FAIL empty_t2 clear=%b done=%b count=%0d valid=%b busy=%b required 1 1 0 0 1",
               clear0, done0, count0, valid0, busy0);
    end
    tick();
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || clear0 !== 1'b0 || valid0 !== 1'b0) begin
      failures++;
      $display("FAIL empty_after busy=%b done=%b clear=%b valid=%b required all 0",
               busy0, done0, clear0, valid0);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] ed [4]   = '{8'h90, 8'h70, 8'h40, 8'h10};
    logic       rdy [7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int         beat [7] = '{0, 1, 1, 1, 2, 2, 3};
    cells_data = 32'h1040_7090;
    cells_meta = {32'd4, 32'd3, 32'd2, 32'd1};
    m_ready = 1'b0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    for (int c = 0; c < 7; c++) begin
      m_ready = rdy[c];
      checks++;
      if (valid0 !== 1'b1 || data0 !== ed[beat[c]] || meta0 !== 32'(beat[c] + 1) ||
          idx0 !== 2'(beat[c]) || last0 !== (beat[c] == 3) || done0 !== 1'b0) begin
        failures++;
        $display("FAIL bp_cycle%0d valid=%b data=%h meta=%0d idx=%0d last=%b done=%b required data=%h idx=%0d",
                 c, valid0, data0, meta0, idx0, last0, done0, ed[beat[c]], beat[c]);
      end
      tick();
    end
    m_ready = 1'b1;
    checks++;
    if (done0 !== 1'b1 || count0 !== 3'd4 || valid0 !== 1'b0) begin
      failures++;
      $display("FAIL bp_done done=%b count=%0d valid=%b required done=1 count=4 valid=0",
               done0, count0, valid0);
    end
    tick();
  endtask

  task automatic test_quiet_wait;
    logic [7:0] ed [4] = '{8'h80, 8'h60, 8'h30, 8'h20};
    logic [31:0] em [4] = '{32'hA, 32'hB, 32'hC, 32'hD};
    cells_data = 32'h1111_1111;
    cells_meta = {4{32'h5}};
    m_ready = 1'b1;
    dav = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (busy0 !== 1'b1 || valid0 !== 1'b0 || clear0 !== 1'b0) begin
        failures++;
        $display("FAIL quiet_hold%0d busy=%b valid=%b clear=%b required 1 0 0", k, busy0, valid0, clear0);
      end
      cells_data = cells_data + 32'h0101_0101;
      tick();
    end
    dav = 1'b0;
    cells_data = 32'h2030_6080;
    cells_meta = {32'hD, 32'hC, 32'hB, 32'hA};
    tick();
    cells_data = 32'hEEEE_EEEE;
    cells_meta = '1;
    start0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (valid0 !== 1'b1 || clear0 !== (i == 0) || data0 !== ed[i] || meta0 !== em[i] ||
          idx0 !== 2'(i) || last0 !== (i == 3)) begin
        failures++;
        $display("FAIL quiet_beat%0d valid=%b clear=%b data=%h meta=%h idx=%0d last=%b required data=%h meta=%h",
                 i, valid0, clear0, data0, meta0, idx0, last0, ed[i], em[i]);
      end
      tick();
      start0 = 1'b0;
    end
    checks++;
    if (done0 !== 1'b1 || count0 !== 3'd4) begin
      failures++;
      $display("FAIL quiet_done done=%b count=%0d required done=1 count=4", done0, count0);
    end
    tick();
    checks++;
    if (busy0 !== 1'b0) begin
      failures++;
      $display("FAIL quiet_start_in_stream busy=%b required 0", busy0);
    end
  endtask

  task automatic test_reset_mid_stream;
    cells_data = 32'h1040_7090;
    cells_meta = {32'd4, 32'd3, 32'd2, 32'd1};
    m_ready = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (valid0 !== 1'b1 || data0 !== 8'h40 || idx0 !== 2'd2) begin
      failures++;
      $display("FAIL rstmid_beat2 valid=%b data=%h idx=%0d required 1 40 2", valid0, data0, idx0);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({valid0, busy0, done0, clear0, last0} !== 5'b0 || idx0 !== 2'd0 || data0 !== 8'h0) begin
      failures++;
      $display("FAIL rstmid_reset valid/busy/done/clear/last=%b idx=%0d data=%h required all 0",
               {valid0, busy0, done0, clear0, last0}, idx0, data0);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (done0 !== 1'b0 || busy0 !== 1'b0 || clear0 !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_after done=%b busy=%b clear=%b required 0 0 0", done0, busy0, clear0);
    end
  endtask

  task automatic test_rev1_single;
    cells_data = 32'hFFFF_FF05;
    cells_meta = {32'd0, 32'd0, 32'd0, 32'd9};
    m_ready = 1'b1;
    start0 = 1'b1;
    start1 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
    tick();
    checks++;
    if (valid1 !== 1'b1 || clear1 !== 1'b1 || data1 !== 8'h05 || meta1 !== 32'd9 ||
        idx1 !== 2'd0 || last1 !== 1'b1) begin
      failures++;
      $display("FAIL rev1_beat valid=%b clear=%b data=%h meta=%0d idx=%0d last=%b required 1 1 05 9 0 1",
               valid1, clear1, data1, meta1, idx1, last1);
    end
    checks++;
    if (valid0 !== 1'b1 || clear0 !== 1'b1 || data0 !== 8'h05 || last0 !== 1'b0) begin
      failures++;
      $display("FAIL rev0_fresh_beat valid=%b clear=%b data=%h last=%b required 1 1 05 0",
               valid0, clear0, data0, last0);
    end
    tick();
    checks++;
    if (done1 !== 1'b1 || count1 !== 3'd1 || valid1 !== 1'b0 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL rev1_done done=%b count=%0d valid=%b busy=%b required 1 1 0 0",
               done1, count1, valid1, busy1);
    end
    tick();
    tick();
    tick();
    checks++;
    if (done0 !== 1'b1 || count0 !== 3'd4) begin
      failures++;
      $display("FAIL rev0_fresh_done done=%b count=%0d required done=1 count=4", done0, count0);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_full_readout();
    test_back_to_back();
    test_early_stop();
    test_empty_sorter();
    test_backpressure();
    test_quiet_wait();
    test_reset_mid_stream();
    test_rev1_single();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
